// File: rtl/commutator.sv
// Brushless motor commutator: Hall decode, brake override and slewed duty,
// all updated once per PWM period.
module commutator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic [11:0] drv_mag,
  input  logic        PWM_synch,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic [10:0] duty,
  output logic        hall_fault
);

  logic [2:0]  hall_s1_q, hall_s2_q;
  logic        brk_s1_q, brk_s2_q;
  logic [5:0]  sel_q, sel_d;
  logic [10:0] duty_q, duty_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [11:0] tgt, dcur, up, dn_lim;
  logic        hall_bad;

  assign hall_bad = (hall_s2_q == 3'b000) || (hall_s2_q == 3'b111);

  always_comb begin
    sel_d = sel_q;
    if (PWM_synch) begin
      if (!brk_s2_q) begin
        sel_d = 6'b11_11_11;
      end else begin
        case (hall_s2_q)
          3'b101:  sel_d = 6'b10_01_00;
          3'b100:  sel_d = 6'b10_00_01;
          3'b110:  sel_d = 6'b00_10_01;
          3'b010:  sel_d = 6'b01_10_00;
          3'b011:  sel_d = 6'b01_00_10;
          3'b001:  sel_d = 6'b00_01_10;
          default: sel_d = 6'b00_00_00;
        endcase
      end
    end
  end

  // 12-bit math so the slew never wraps near the top or bottom of the range
  always_comb begin
    tgt    = brk_s2_q ? (12'h400 + (drv_mag >> 2)) : 12'h600;
    dcur   = {1'b0, duty_q};
    up     = dcur + 12'd16;
    dn_lim = tgt + 12'd16;
    duty_d = duty_q;
    if (PWM_synch) begin
      if (!brk_s2_q) begin
        duty_d = tgt[10:0];
      end else if (dcur < tgt) begin
        duty_d = (up > tgt) ? tgt[10:0] : up[10:0];
      end else if (dcur > tgt) begin
        duty_d = (dcur >= dn_lim) ? (duty_q - 11'd16) : tgt[10:0];
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (PWM_synch) begin
      if (hall_bad) begin
        cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
      end else begin
        cnt_d = 2'd0;
      end
      fault_d = cnt_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hall_s1_q <= 3'b000;
      hall_s2_q <= 3'b000;
      brk_s1_q  <= 1'b0;
      brk_s2_q  <= 1'b0;
      sel_q     <= 6'b0;
      duty_q    <= 11'h400;
      cnt_q     <= 2'd0;
      fault_q   <= 1'b0;
    end else begin
      hall_s1_q <= {hallGrn, hallYlw, hallBlu};
      hall_s2_q <= hall_s1_q;
      brk_s1_q  <= brake_n;
      brk_s2_q  <= brk_s1_q;
      sel_q     <= sel_d;
      duty_q    <= duty_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign selGrn     = sel_q[5:4];
  assign selYlw     = sel_q[3:2];
  assign selBlu     = sel_q[1:0];
  assign duty       = duty_q;
  assign hall_fault = fault_q;

endmodule
